// File: rtl/ysyx_rd_arbiter.sv
// ysyx_rd_arbiter: shares one AXI4 read channel (AR/R) between the IFU fetch port and the LSU load port.
// Optional feature macro YSYX_RD_ARB_FLUSH_EN adds ifu_flush to discard an in-flight fetch response.
module ysyx_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [31:0]       ifu_rdata_o,
    output logic              ifu_rvalid_o,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    input  logic              lsu_arvalid,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_rvalid_o,
    output logic              rerr_o,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic              io_master_arvalid,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_arready,
    input  logic [63:0]       io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic [3:0]        io_master_rid,
    input  logic              io_master_rlast,
    input  logic              io_master_rvalid,
    output logic              io_master_rready
`ifdef YSYX_RD_ARB_FLUSH_EN
    ,
    input  logic              ifu_flush
`endif
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              gnt_lsu_q, gnt_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              drop_q, drop_d;
    logic              resp_q, resp_d;
    logic              ifu_rvalid_q, ifu_rvalid_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0]       ifu_rdata_q, ifu_rdata_d;
    logic [31:0]       lsu_rdata_q, lsu_rdata_d;
    logic              rerr_q, rerr_d;

    logic              starve_full_s;
    logic              pick_lsu_s;
    logic              pick_ifu_s;
    logic              start_s;
    logic              capture_s;
    logic              flush_s;
    logic              suppress_s;
    logic [31:0]       lane_s;
    logic              err_s;

    assign starve_full_s = (starve_q == CNT_W'(STARVE_MAX));

    // The cycle a response is delivered is a bubble: the finished requester's level request is masked.
    assign pick_lsu_s = (state_q == S_IDLE) && !resp_q && lsu_arvalid && !(ifu_arvalid && starve_full_s);
    assign pick_ifu_s = (state_q == S_IDLE) && !resp_q && ifu_arvalid && !pick_lsu_s;
    assign start_s    = pick_lsu_s || pick_ifu_s;

    assign capture_s  = (state_q == S_DATA) && io_master_rvalid && io_master_rlast;
    assign lane_s     = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
    assign err_s      = (io_master_rresp != 2'b00) || (io_master_rid != {3'b000, gnt_lsu_q});

`ifdef YSYX_RD_ARB_FLUSH_EN
    assign flush_s = ifu_flush && (pick_ifu_s || ((state_q != S_IDLE) && !gnt_lsu_q));
`else
    assign flush_s = 1'b0;
`endif
    assign suppress_s = drop_q || flush_s;

    // Next-state logic for the grant FSM, starvation counter and response registers
    always_comb begin
        state_d      = state_q;
        gnt_lsu_d    = gnt_lsu_q;
        addr_d       = addr_q;
        size_d       = size_q;
        starve_d     = starve_q;
        drop_d       = drop_q;
        resp_d       = 1'b0;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        ifu_rdata_d  = 32'd0;
        lsu_rdata_d  = 32'd0;
        rerr_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                drop_d = flush_s;
                if (start_s) begin
                    state_d   = S_ADDR;
                    gnt_lsu_d = pick_lsu_s;
                    if (pick_lsu_s) begin
                        addr_d = lsu_araddr;
                        size_d = lsu_arsize;
                        if (ifu_arvalid && !starve_full_s) begin
                            starve_d = starve_q + CNT_W'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end else begin
                        addr_d   = ifu_araddr;
                        size_d   = 3'd2;
                        starve_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                drop_d = suppress_s;
                if (io_master_arready) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                drop_d = suppress_s;
                if (capture_s) begin
                    state_d      = S_IDLE;
                    drop_d       = 1'b0;
                    resp_d       = 1'b1;
                    lsu_rvalid_d = gnt_lsu_q;
                    ifu_rvalid_d = !gnt_lsu_q && !suppress_s;
                    lsu_rdata_d  = gnt_lsu_q ? lane_s : 32'd0;
                    ifu_rdata_d  = (!gnt_lsu_q && !suppress_s) ? lane_s : 32'd0;
                    rerr_d       = err_s && (gnt_lsu_q || !suppress_s);
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any beat in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_lsu_q    <= 1'b0;
            addr_q       <= '0;
            size_q       <= 3'd0;
            starve_q     <= '0;
            drop_q       <= 1'b0;
            resp_q       <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= 32'd0;
            lsu_rdata_q  <= 32'd0;
            rerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_lsu_q    <= gnt_lsu_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            starve_q     <= starve_d;
            drop_q       <= drop_d;
            resp_q       <= resp_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            rerr_q       <= rerr_d;
        end
    end

    assign ifu_rvalid_o      = ifu_rvalid_q;
    assign ifu_rdata_o       = ifu_rdata_q;
    assign lsu_rvalid_o      = lsu_rvalid_q;
    assign lsu_rdata_o       = lsu_rdata_q;
    assign rerr_o            = rerr_q;

    assign io_master_araddr  = addr_q;
    assign io_master_arvalid = (state_q == S_ADDR);
    assign io_master_arid    = {3'b000, gnt_lsu_q};
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = (state_q == S_ADDR) ? 2'b01 : 2'b00;
    assign io_master_rready  = (state_q == S_DATA);

endmodule

// File: tb/tb_ysyx_rd_arbiter.sv
// Scoreboard bench for ysyx_rd_arbiter: directed requests, a small AXI slave, and a monitor that checks AR and responses.
`timescale 1ns/1ps
module tb_ysyx_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr;
    logic        ifu_arvalid, lsu_arvalid;
    logic [2:0]  lsu_arsize;
    logic [31:0] ifu_rdata_o, lsu_rdata_o;
    logic        ifu_rvalid_o, lsu_rvalid_o, rerr_o;
    logic [31:0] io_master_araddr;
    logic        io_master_arvalid, io_master_arready;
    logic [3:0]  io_master_arid, io_master_rid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst, io_master_rresp;
    logic [63:0] io_master_rdata;
    logic        io_master_rlast, io_master_rvalid, io_master_rready;
`ifdef YSYX_RD_ARB_FLUSH_EN
    logic        ifu_flush;
`endif

    always #5 clk = ~clk;

    ysyx_rd_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .rerr_o(rerr_o),
        .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
        .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_arready(io_master_arready), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rid(io_master_rid),
        .io_master_rlast(io_master_rlast), .io_master_rvalid(io_master_rvalid),
        .io_master_rready(io_master_rready)
`ifdef YSYX_RD_ARB_FLUSH_EN
        , .ifu_flush(ifu_flush)
`endif
    );

    typedef struct packed { logic is_lsu; logic [31:0] data; logic err; } resp_t;
    typedef struct packed { logic [31:0] addr; logic [3:0] id; logic [2:0] size; } ar_t;

    resp_t resp_q[$];
    ar_t   ar_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    // slave configuration
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [63:0] ifu_beat = 64'h0;
    logic [63:0] lsu_beat = 64'h0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [3:0]  rid_xor = 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI slave: arready after ar_delay cycles, single R beat after r_delay cycles
    initial begin : slave
        logic s_ar_hs, s_r_hs, s_pend;
        logic [3:0] s_id;
        int s_ar_cnt, s_r_cnt;
        s_pend = 1'b0; s_id = 4'h0; s_ar_cnt = 0; s_r_cnt = 0;
        io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        io_master_rdata = 64'h0; io_master_rresp = 2'b00; io_master_rid = 4'h0;
        forever begin
            @(negedge clk);
            s_ar_hs = io_master_arvalid & io_master_arready;
            s_r_hs  = io_master_rvalid & io_master_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
                s_pend = 1'b0; s_ar_cnt = 0; s_r_cnt = 0;
            end else begin
                if (s_r_hs) begin
                    io_master_rvalid = 1'b0; io_master_rlast = 1'b0; s_pend = 1'b0;
                end
                if (s_ar_hs) begin
                    s_pend = 1'b1; s_id = io_master_arid; s_r_cnt = 0;
                end
                if (!s_pend && io_master_arvalid) begin
                    if (s_ar_cnt >= ar_delay) io_master_arready = 1'b1;
                    else begin io_master_arready = 1'b0; s_ar_cnt++; end
                end else begin
                    io_master_arready = 1'b0; s_ar_cnt = 0;
                end
                if (s_pend && !io_master_rvalid) begin
                    if (s_r_cnt >= r_delay) begin
                        io_master_rvalid = 1'b1; io_master_rlast = 1'b1;
                        io_master_rdata  = (s_id == 4'h0) ? ifu_beat : lsu_beat;
                        io_master_rresp  = rresp_cfg;
                        io_master_rid    = s_id ^ rid_xor;
                    end else begin
                        s_r_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: compare AR requests and responses against the scoreboard queues
    initial begin : monitor
        resp_t e;
        ar_t   a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (io_master_arvalid) begin
                    if (ar_q.size() == 0) check("unexpected_ar", 64'(io_master_arvalid), 64'd0);
                    else begin
                        a = ar_q[0];
                        check("ar_addr", 64'(io_master_araddr), 64'(a.addr));
                        check("ar_id", 64'(io_master_arid), 64'(a.id));
                        check("ar_size", 64'(io_master_arsize), 64'(a.size));
                        check("ar_len", 64'(io_master_arlen), 64'd0);
                        check("ar_burst", 64'(io_master_arburst), 64'd1);
                        if (io_master_arready) ar_q.delete(0);
                    end
                end
                if (ifu_rvalid_o || lsu_rvalid_o) begin
                    if (resp_q.size() == 0) check("unexpected_resp", 64'({ifu_rvalid_o, lsu_rvalid_o}), 64'd0);
                    else begin
                        e = resp_q.pop_front();
                        check("resp_port", 64'({ifu_rvalid_o, lsu_rvalid_o}), e.is_lsu ? 64'd1 : 64'd2);
                        check("resp_data", 64'(e.is_lsu ? lsu_rdata_o : ifu_rdata_o), 64'(e.data));
                        check("resp_err", 64'(rerr_o), 64'(e.err));
                    end
                end else if (rerr_o) begin
                    check("stray_rerr", 64'(rerr_o), 64'd0);
                end
            end
        end
    end

    task automatic wait_resp(input bit lsu, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (lsu ? lsu_rvalid_o : ifu_rvalid_o) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_resp_%s: no response within %0d cycles", lsu ? "lsu" : "ifu", budget);
        end
    endtask

    task automatic wait_rready(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (io_master_rready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_rready: rready not seen within %0d cycles", budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        rst = 1'b1;
        ifu_araddr = 32'h0; ifu_arvalid = 1'b0;
        lsu_araddr = 32'h0; lsu_arvalid = 1'b0; lsu_arsize = 3'd0;
`ifdef YSYX_RD_ARB_FLUSH_EN
        ifu_flush = 1'b0;
`endif
        ifu_beat = 64'hDEAD_BEEF_0000_0013;
        lsu_beat = 64'hCAFE_F00D_1234_5678;
        idle(3);
        check("rst_arvalid", 64'(io_master_arvalid), 64'd0);
        check("rst_rready", 64'(io_master_rready), 64'd0);
        check("rst_rvalid", 64'({ifu_rvalid_o, lsu_rvalid_o, rerr_o}), 64'd0);
        check("rst_araddr", 64'(io_master_araddr), 64'd0);
        check("rst_arburst", 64'(io_master_arburst), 64'd0);
        rst = 1'b0;
        idle(2);

        // IFU alone, upper lane, minimum latency
        ar_q.push_back(ar_t'{32'h3000_0004, 4'd0, 3'd2});
        resp_q.push_back(resp_t'{1'b0, 32'hDEAD_BEEF, 1'b0});
        ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1;
        wait_resp(1'b0, 50, lat);
        check("ifu_latency", 64'(lat), 64'd3);
        idle(1); ifu_arvalid = 1'b0;
        idle(3);

        // Both at once: LSU first, IFU issued only after the LSU response
        ar_q.push_back(ar_t'{32'h8000_0000, 4'd1, 3'd0});
        ar_q.push_back(ar_t'{32'h3000_0004, 4'd0, 3'd2});
        resp_q.push_back(resp_t'{1'b1, 32'h1234_5678, 1'b0});
        resp_q.push_back(resp_t'{1'b0, 32'hDEAD_BEEF, 1'b0});
        lsu_araddr = 32'h8000_0000; lsu_arsize = 3'd0; lsu_arvalid = 1'b1;
        ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1;
        wait_resp(1'b1, 50, lat);
        check("lsu_first_latency", 64'(lat), 64'd3);
        idle(1); lsu_arvalid = 1'b0;
        wait_resp(1'b0, 50, lat);
        check("ifu_after_lsu", 64'(lat), 64'd3);
        idle(1); ifu_arvalid = 1'b0;
        idle(3);

        // Starvation: LSU held, IFU waiting -> four LSU grants then IFU
        for (int i = 0; i < 4; i++) begin
            ar_q.push_back(ar_t'{32'h8000_0004, 4'd1, 3'd2});
            resp_q.push_back(resp_t'{1'b1, 32'hCAFE_F00D, 1'b0});
        end
        ar_q.push_back(ar_t'{32'h3000_0000, 4'd0, 3'd2});
        resp_q.push_back(resp_t'{1'b0, 32'h0000_0013, 1'b0});
        lsu_araddr = 32'h8000_0004; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
        ifu_araddr = 32'h3000_0000; ifu_arvalid = 1'b1;
        wait_resp(1'b0, 200, lat);
        idle(1); lsu_arvalid = 1'b0; ifu_arvalid = 1'b0;
        check("starve_resp_pending", 64'(resp_q.size()), 64'd0);
        check("starve_cnt_cleared", 64'(dut.starve_q), 64'd0);
        idle(3);

        // arready stalled 5 cycles, R beat 3 cycles late
        ar_delay = 5; r_delay = 3;
        ar_q.push_back(ar_t'{32'h8000_0008, 4'd1, 3'd1});
        resp_q.push_back(resp_t'{1'b1, 32'h1234_5678, 1'b0});
        lsu_araddr = 32'h8000_0008; lsu_arsize = 3'd1; lsu_arvalid = 1'b1;
        wait_resp(1'b1, 100, lat);
        check("stall_latency", 64'(lat), 64'd11);
        idle(1); lsu_arvalid = 1'b0;
        ar_delay = 0; r_delay = 0;
        idle(3);

        // SLVERR on LSU read
        rresp_cfg = 2'b10;
        ar_q.push_back(ar_t'{32'h8000_000C, 4'd1, 3'd2});
        resp_q.push_back(resp_t'{1'b1, 32'hCAFE_F00D, 1'b1});
        lsu_araddr = 32'h8000_000C; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
        wait_resp(1'b1, 50, lat);
        idle(1); lsu_arvalid = 1'b0;
        rresp_cfg = 2'b00;
        idle(3);

        // rid mismatch on IFU read
        rid_xor = 4'h2;
        ar_q.push_back(ar_t'{32'h3000_0008, 4'd0, 3'd2});
        resp_q.push_back(resp_t'{1'b0, 32'h0000_0013, 1'b1});
        ifu_araddr = 32'h3000_0008; ifu_arvalid = 1'b1;
        wait_resp(1'b0, 50, lat);
        idle(1); ifu_arvalid = 1'b0;
        rid_xor = 4'h0;
        idle(3);

`ifdef YSYX_RD_ARB_FLUSH_EN
        // Flush in DATA: R handshake completes, no IFU response, next fetch normal
        r_delay = 3;
        ar_q.push_back(ar_t'{32'h3000_0004, 4'd0, 3'd2});
        ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1;
        wait_rready(50);
        idle(1); ifu_flush = 1'b1; ifu_arvalid = 1'b0;
        idle(1); ifu_flush = 1'b0;
        idle(8);
        check("flush_rready_done", 64'(io_master_rready), 64'd0);
        r_delay = 0;
        ar_q.push_back(ar_t'{32'h3000_0000, 4'd0, 3'd2});
        resp_q.push_back(resp_t'{1'b0, 32'h0000_0013, 1'b0});
        ifu_araddr = 32'h3000_0000; ifu_arvalid = 1'b1;
        wait_resp(1'b0, 50, lat);
        check("flush_next_latency", 64'(lat), 64'd3);
        idle(1); ifu_arvalid = 1'b0;
        idle(3);
`endif

        // Reset while in DATA: outputs drop at once, nothing delivered afterwards
        r_delay = 4;
        ar_q.push_back(ar_t'{32'h3000_0004, 4'd0, 3'd2});
        ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1;
        wait_rready(50);
        #1;
        rst = 1'b1; ifu_arvalid = 1'b0;
        #1;
        check("midrst_rready", 64'(io_master_rready), 64'd0);
        check("midrst_arvalid", 64'(io_master_arvalid), 64'd0);
        check("midrst_outs", 64'({ifu_rvalid_o, lsu_rvalid_o, rerr_o}), 64'd0);
        idle(2);
        rst = 1'b0;
        r_delay = 0;
        idle(12);

        check("ar_queue_empty", 64'(ar_q.size()), 64'd0);
        check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
